// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family.
package seq_det_pkg;

  // Occupancy of the history window, used for debug visibility and assertions.
  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_FILLING = 2'd1,
    FILL_FULL    = 2'd2
  } fill_state_t;

  // Pattern searched for after reset; MSB is the first bit received.
  localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1010;

  // Classify a fill count against the window length.
  function automatic fill_state_t fill_state_of(input int unsigned fill,
                                                input int unsigned pat_w);
    if (fill == 0)          return FILL_EMPTY;
    else if (fill >= pat_w) return FILL_FULL;
    else                    return FILL_FILLING;
  endfunction

endpackage

// File: rtl/seq_detect_moore_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count up on inc, never wrapping past the maximum value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_moore_param.sv
// Runtime-programmable serial pattern detector with a registered (Moore)
// one-cycle detect pulse and a saturating match counter.
//
// fill state   | meaning
// FILL_EMPTY   | no valid history bits (after reset, load, or non-overlap hit)
// FILL_FILLING | some but not all window bits collected
// FILL_FULL    | window full; every enabled bit is a candidate match
module seq_detect_moore_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQ_DEFAULT_PAT),
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             c,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             d,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat, pat_nx;
  logic [PAT_W-1:0]  hist, hist_nx, hist_sh;
  logic [FILL_W-1:0] fill, fill_nx, fill_inc;
  logic              match;
  fill_state_t       fill_state;

  assign fill_state = fill_state_of(32'(fill), PAT_W);

  // Next-state: load beats sampling; a compare only counts once the window is full.
  always_comb begin
    pat_nx   = pat;
    hist_nx  = hist;
    fill_nx  = fill;
    match    = 1'b0;
    hist_sh  = {hist[PAT_W-2:0], c};
    fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;
    if (pat_load) begin
      pat_nx  = pat_in;
      hist_nx = '0;
      fill_nx = '0;
    end else if (en) begin
      hist_nx = hist_sh;
      match   = (fill_inc == FILL_MAX) && (hist_sh == pat);
      // hist is kept on a non-overlap hit; the zeroed fill blocks stale compares.
      fill_nx = (match && !overlap) ? '0 : fill_inc;
    end
  end

  // State register; d is simply the match of the previous edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat  <= DEFAULT_PAT;
      hist <= '0;
      fill <= '0;
      d    <= 1'b0;
    end else begin
      pat  <= pat_nx;
      hist <= hist_nx;
      fill <= fill_nx;
      d    <= match;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (1'b0),
    .q     (match_cnt)
  );

  // Window occupancy never exceeds the pattern length.
  a_fill_range: assert property (@(posedge clk) disable iff (!reset)
    fill <= FILL_MAX);

  // A pulse leaves the window either full (overlap) or empty (non-overlap).
  a_fill_after_hit: assert property (@(posedge clk) disable iff (!reset)
    d |-> (fill_state == FILL_FULL || fill_state == FILL_EMPTY));

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Directed bench for seq_detect_moore_param: vector table plus hand sequences.
module tb_seq_detect_moore_param;

  logic       clk;
  logic       reset;
  logic       en, c, overlap, pat_load;
  logic [3:0] pat_in;
  logic       d, d2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       c;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       exp_d;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   run_cnt;

  seq_detect_moore_param #(.PAT_W(4), .DEFAULT_PAT(4'b1010), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .c(c), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .d(d), .match_cnt(match_cnt)
  );

  seq_detect_moore_param #(.PAT_W(4), .DEFAULT_PAT(4'b1111), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .c(c), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .d(d2), .match_cnt(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic cc, input logic ov, input logic ld,
                     input logic [3:0] pin, input logic ed);
    vec_t v;
    if (ed) run_cnt++;
    v.en = e; v.c = cc; v.overlap = ov; v.pat_load = ld; v.pat_in = pin;
    v.exp_d = ed; v.exp_cnt = 8'(run_cnt);
    vecs.push_back(v);
  endtask

  task automatic step(input logic e, input logic cc, input logic ov, input logic ld,
                      input logic [3:0] pin);
    en = e; c = cc; overlap = ov; pat_load = ld; pat_in = pin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [14:0] s, hn, ho;
    logic [6:0]  r, rh1, rh0;
    logic [3:0]  g;
    int          sat_cnt[8];

    en = 0; c = 0; overlap = 0; pat_load = 0; pat_in = 4'b0000;
    reset = 1'b0;

    // ---------------- vector table ----------------
    run_cnt = 0;
    s  = 15'b110101011101010;
    hn = 15'b000010000000100;   // non-overlap hits at idx 4, 12
    ho = 15'b000010100000101;   // overlap hits at idx 4, 6, 12, 14
    for (int i = 0; i < 15; i++) add(1, s[14-i], 0, 0, 4'b0000, hn[14-i]);
    add(1, 1, 1, 1, 4'b1010, 0);                  // restart search, count held
    for (int i = 0; i < 15; i++) add(1, s[14-i], 1, 0, 4'b0000, ho[14-i]);

    add(1, 1, 1, 0, 4'b0000, 0);
    add(1, 1, 1, 0, 4'b0000, 0);
    add(0, 0, 1, 1, 4'b0110, 0);
    r   = 7'b0110110;
    rh1 = 7'b0001001;
    rh0 = 7'b0001000;
    for (int i = 0; i < 7; i++) add(1, r[6-i], 1, 0, 4'b0000, rh1[6-i]);
    add(0, 0, 0, 1, 4'b0110, 0);
    for (int i = 0; i < 7; i++) add(1, r[6-i], 0, 0, 4'b0000, rh0[6-i]);

    add(0, 0, 0, 1, 4'b1010, 0);
    g = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      add(1, g[3-i], 0, 0, 4'b0000, (i == 3));
      if (i < 3) for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 4'b0000, 0);
    end
    add(0, 0, 0, 0, 4'b0000, 0);
    add(0, 0, 0, 0, 4'b0000, 0);

    add(1, 1, 0, 0, 4'b0000, 0);
    add(1, 0, 0, 0, 4'b0000, 0);
    add(1, 1, 0, 0, 4'b0000, 0);
    add(1, 0, 0, 1, 4'b1010, 0);                  // load wins over would-be match
    add(1, 0, 0, 0, 4'b0000, 0);

    // ---------------- reset ----------------
    @(posedge clk); @(posedge clk); #1;
    chk("rst_d", d, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_d_sat", d2, 0);
    chk("rst_cnt_sat", 8'(cnt2), 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].c, vecs[i].overlap, vecs[i].pat_load, vecs[i].pat_in);
      chk($sformatf("vec%0d_d", i), d, vecs[i].exp_d);
      chk($sformatf("vec%0d_cnt", i), match_cnt, vecs[i].exp_cnt);
    end
    chk("table_final_cnt", match_cnt, 10);

    // ------- async reset mid-pattern drops a loaded pattern -------
    step(0, 0, 0, 1, 4'b0110);
    step(1, 0, 0, 0, 4'b0000);
    step(1, 1, 0, 0, 4'b0000);
    step(1, 1, 0, 0, 4'b0000);
    reset = 1'b0;
    #1;
    chk("midrst_cnt_async", match_cnt, 0);
    chk("midrst_d_async", d, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    step(1, 0, 0, 0, 4'b0000); chk("dflt_b1", d, 0);
    step(1, 1, 0, 0, 4'b0000); chk("dflt_b2", d, 0);
    step(1, 0, 0, 0, 4'b0000); chk("dflt_b3", d, 0);
    chk("dflt_cnt0", match_cnt, 0);
    step(1, 1, 0, 0, 4'b0000); chk("dflt_b4_no0110", d, 0);
    step(1, 0, 0, 0, 4'b0000); chk("dflt_1010_hit", d, 1);
    chk("dflt_cnt1", match_cnt, 1);

    // ---------------- saturation (CNT_W=2, all ones) ----------------
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    sat_cnt = '{0, 0, 0, 1, 2, 3, 3, 3};
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 0, 4'b0000);
      chk($sformatf("sat%0d_d", i), d2, (i >= 3));
      chk($sformatf("sat%0d_cnt", i), 8'(cnt2), 8'(sat_cnt[i]));
      chk($sformatf("sat%0d_main_d", i), d, 0);
    end
    reset = 1'b0;
    #1;
    chk("sat_async_d", d2, 0);
    chk("sat_async_cnt", 8'(cnt2), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
